uart_receiver_param: RTL and testbench
======================================

UART_RECEIVER_PARAM -- requirements
Module: uart_receiver_param

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving the payload bits per frame (legal range 5..9).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, giving the enabled clock cycles per bit (legal range 4..255).
REQ-003 The block SHALL have parameter PARITY, default 0, selecting the parity mode (0 none, 1 even, 2 odd).
REQ-004 The block SHALL have parameter STOP_BITS, default 1, giving the number of stop bits (legal values 1 or 2).
REQ-005 The block SHALL have port CLKIN, input, 1 bit: the single clock, with all state changing on its rising edge.
REQ-006 The block SHALL have port RESETN, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port clock_enable, input, 1 bit: all non-reset state updates occur only on CLKIN edges where clock_enable=1.
REQ-008 The block SHALL have port rx, input, 1 bit: the serial line, idle high, asynchronous to CLKIN.
REQ-009 The block SHALL have port ready, input, 1 bit: consumer accept.
REQ-010 The block SHALL have port data, output, DATA_BITS wide: the received payload, LSB first on the line.
REQ-011 The block SHALL have port valid, output, 1 bit: data and the flags are meaningful.
REQ-012 The block SHALL have port parity_err, output, 1 bit: parity mismatch on the held frame (always 0 when PARITY=0).
REQ-013 The block SHALL have port frame_err, output, 1 bit: a stop bit of the held frame was sampled 0.
REQ-014 The block SHALL have port overrun, output, 1 bit: sticky, set when an unaccepted frame was overwritten.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer before use; all timing below refers to the synchronized rx.
REQ-016 The state machine SHALL have states IDLE, START, DATA, PAR, STOP.
- IDLE->START on rx=0.
- START->DATA, DATA->PAR (PAR only when PARITY!=0) or ->STOP, STOP->IDLE.
REQ-017 In START, rx SHALL be sampled after CLKS_PER_BIT/2 (floor) enabled cycles; if rx=1 the FSM SHALL return to IDLE with no output change (glitch reject).
REQ-018 Each later bit SHALL be sampled exactly CLKS_PER_BIT enabled cycles after the previous sample, using a bit counter of width clog2(DATA_BITS+1) and a sample counter of width clog2(CLKS_PER_BIT).
REQ-019 Parity SHALL be checked as follows: the XOR of the data bits and the parity bit must equal 0 for even parity and 1 for odd; a mismatch sets parity_err.
REQ-020 All STOP_BITS stop bits SHALL be sampled; if any is 0, frame_err=1 and the frame is still delivered (a break therefore yields data=0 with frame_err=1).
REQ-021 On the edge sampling the final stop bit, the block SHALL load data, parity_err and frame_err, set valid=1, and return to IDLE, so back-to-back frames are received with no gap.
REQ-022 A transfer SHALL occur on an enabled edge with valid=1 and ready=1; valid falls on that edge unless a new frame loads on the same edge.
REQ-023 If a frame completes while valid=1 and ready=0: data and flags SHALL be overwritten, valid stays 1, and overrun is set.
REQ-024 If a frame completes on the same edge as a transfer: the old frame SHALL be consumed, the new frame is loaded, valid stays 1, and overrun is unchanged.
REQ-025 overrun SHALL clear only on a transfer that does not itself coincide with an overwrite.
REQ-026 With clock_enable=0, all state and outputs SHALL hold.

Reset
REQ-027 While RESETN=0, asynchronously: FSM=IDLE; counters=0; synchronizer flops=1; data=0; valid, parity_err, frame_err and overrun=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame, which is never delivered; reception resumes at the first falling edge on rx after release.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state enum, the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and a clog2 function.
REQ-030 One sub-module, uart_rx_sampler, SHALL contain the synchronizer and the sample counter, emitting a one-cycle sample strobe and the synchronized rx.

Verification
REQ-031 Defaults, ready=1, send 0xA5 -> data=0xA5, valid high for 1 enabled cycle, all flags 0.
REQ-032 PARITY=1, send 0x3C with parity bit 1 -> data=0x3C, parity_err=1; repeat with parity bit 0 -> parity_err=0.
REQ-033 rx low for 4 cycles, then high -> FSM back in IDLE, valid never asserts.
REQ-034 ready=0, send 0x11 then 0x22 -> data=0x22, overrun=1; then ready=1 for one cycle -> valid=0, overrun=0.
REQ-035 STOP_BITS=2, second stop bit 0, data 0x7E -> data=0x7E, frame_err=1, valid=1.
REQ-036 RESETN pulsed low during data bit 3, then send 0x5A -> all outputs 0 during reset; afterwards exactly one frame, data=0x5A, no flags.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parameterised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Ceiling log2; returns 0 for values of 1 or less.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rx synchronizer plus the bit-timing counter that emits a sample strobe
// half a bit into START and one full bit period after every later sample.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clock_enable,
    input  logic rx,
    input  logic active,
    input  logic half,
    output logic rx_sync,
    output logic sample_stb
);

    localparam int CNT_W = clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_cnt;

    always_comb begin
        sync_d     = sync_q;
        cnt_d      = cnt_q;
        sample_stb = 1'b0;
        last_cnt   = half ? HALF_LAST : FULL_LAST;
        if (clock_enable) begin
            sync_d = {sync_q[0], rx};
            // The counter restarts at every strobe so samples stay one bit apart.
            if (active) begin
                if (cnt_q == last_cnt) begin
                    sample_stb = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rx_sync = sync_q[1];

endmodule

// File: rtl/uart_receiver_param.sv
// Parameterised UART receiver with optional parity, 1/2 stop bits and a
// valid/ready output holding register with sticky overrun.
module uart_receiver_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 CLKIN,
    input  logic                 RESETN,
    input  logic                 clock_enable,
    input  logic                 rx,
    input  logic                 ready,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int BIT_W = clog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic             ODD_SENSE = (PARITY == PAR_ODD);

    rx_state_t            state_q, state_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop_err_q, stop_err_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic rx_sync;
    logic sample_stb;
    logic load;
    logic transfer;
    logic stop_bad;
    logic par_mismatch;

    uart_rx_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .clk         (CLKIN),
        .rst_n       (RESETN),
        .clock_enable(clock_enable),
        .rx          (rx),
        .active      (state_q != IDLE),
        .half        (state_q == START),
        .rx_sync     (rx_sync),
        .sample_stb  (sample_stb)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        stop_err_d   = stop_err_q;
        data_d       = data_q;
        valid_d      = valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        load         = 1'b0;
        stop_bad     = stop_err_q | ~rx_sync;
        par_mismatch = (PARITY != PAR_NONE) && ((^shift_q ^ par_bit_q) != ODD_SENSE);
        transfer     = clock_enable && valid_q && ready;

        case (state_q)
            IDLE: begin
                if (clock_enable && !rx_sync) begin
                    state_d   = START;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (sample_stb) begin
                    if (rx_sync) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = DATA;
                        bit_cnt_d  = '0;
                        stop_err_d = 1'b0;
                    end
                end
            end
            DATA: begin
                if (sample_stb) begin
                    shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? PAR : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            PAR: begin
                if (sample_stb) begin
                    par_bit_d = rx_sync;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (sample_stb) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        load      = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        stop_err_d = stop_bad;
                        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A completing frame wins over the consumer; overrun only clears on a
        // plain transfer, and is left alone when consume and load coincide.
        if (load) begin
            data_d       = shift_q;
            parity_err_d = par_mismatch;
            frame_err_d  = stop_bad;
            valid_d      = 1'b1;
            if (valid_q && !transfer) begin
                overrun_d = 1'b1;
            end
        end else if (transfer) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            stop_err_q   <= stop_err_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_receiver_param.sv
// Directed bench: default, even-parity and two-stop-bit receivers side by side.
module tb_uart_receiver_param;

    localparam int CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic ce;
    logic rx_def, rx_par, rx_s2;
    logic rdy_def, rdy_par, rdy_s2;

    logic [7:0] data_def, data_par, data_s2;
    logic valid_def, pe_def, fe_def, ov_def;
    logic valid_par, pe_par, fe_par, ov_par;
    logic valid_s2, pe_s2, fe_s2, ov_s2;

    int vectors = 0;
    int miscompares = 0;

    uart_receiver_param u_def (
        .CLKIN(clk), .RESETN(rst_n), .clock_enable(ce), .rx(rx_def), .ready(rdy_def),
        .data(data_def), .valid(valid_def), .parity_err(pe_def), .frame_err(fe_def),
        .overrun(ov_def)
    );

    uart_receiver_param #(.PARITY(1)) u_par (
        .CLKIN(clk), .RESETN(rst_n), .clock_enable(ce), .rx(rx_par), .ready(rdy_par),
        .data(data_par), .valid(valid_par), .parity_err(pe_par), .frame_err(fe_par),
        .overrun(ov_par)
    );

    uart_receiver_param #(.STOP_BITS(2)) u_s2 (
        .CLKIN(clk), .RESETN(rst_n), .clock_enable(ce), .rx(rx_s2), .ready(rdy_s2),
        .data(data_s2), .valid(valid_s2), .parity_err(pe_s2), .frame_err(fe_s2),
        .overrun(ov_s2)
    );

    // Valid-cycle counters and last-delivered captures for the pulsed cases.
    int vcnt_def = 0;
    int vcnt_par = 0;
    logic [7:0] cap_data_def = 8'h00;
    logic [7:0] cap_data_par = 8'h00;
    logic cap_pe_def = 1'b0;
    logic cap_fe_def = 1'b0;
    logic cap_pe_par = 1'b0;

    always @(negedge clk) begin
        if (valid_def) begin
            vcnt_def++;
            cap_data_def = data_def;
            cap_pe_def   = pe_def;
            cap_fe_def   = fe_def;
        end
        if (valid_par) begin
            vcnt_par++;
            cap_data_par = data_par;
            cap_pe_par   = pe_par;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // bits[0] is the first bit on the line (start bit).
    task automatic send_frame(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            case (sel)
                0:       rx_def = bits[i];
                1:       rx_par = bits[i];
                default: rx_s2  = bits[i];
            endcase
            repeat (CPB) @(negedge clk);
        end
        rx_def = 1'b1;
        rx_par = 1'b1;
        rx_s2  = 1'b1;
    endtask

    int base;

    initial begin
        rx_def = 1'b1; rx_par = 1'b1; rx_s2 = 1'b1;
        rdy_def = 1'b1; rdy_par = 1'b1; rdy_s2 = 1'b1;
        ce = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data",  32'(data_def), 32'h0);
        check("reset_valid", 32'(valid_def), 32'h0);
        check("reset_pe",    32'(pe_def), 32'h0);
        check("reset_fe",    32'(fe_def), 32'h0);
        check("reset_ov",    32'(ov_def), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Default frame 0xA5, ready high: one-cycle valid pulse.
        base = vcnt_def;
        send_frame(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
        repeat (4) @(negedge clk);
        check("a5_vcycles", 32'(vcnt_def - base), 32'd1);
        check("a5_data",    32'(cap_data_def), 32'hA5);
        check("a5_pe",      32'(cap_pe_def), 32'h0);
        check("a5_fe",      32'(cap_fe_def), 32'h0);
        check("a5_ov",      32'(ov_def), 32'h0);
        check("a5_valid_gone", 32'(valid_def), 32'h0);

        // Even parity: 0x3C has four ones, so parity bit 1 is wrong, 0 is right.
        base = vcnt_par;
        send_frame(1, {5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
        repeat (4) @(negedge clk);
        check("par1_vcycles", 32'(vcnt_par - base), 32'd1);
        check("par1_data",    32'(cap_data_par), 32'h3C);
        check("par1_pe",      32'(cap_pe_par), 32'h1);
        base = vcnt_par;
        send_frame(1, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);
        repeat (4) @(negedge clk);
        check("par0_vcycles", 32'(vcnt_par - base), 32'd1);
        check("par0_data",    32'(cap_data_par), 32'h3C);
        check("par0_pe",      32'(cap_pe_par), 32'h0);

        // Short low glitch is rejected, and the next real frame still decodes.
        base = vcnt_def;
        rx_def = 1'b0;
        repeat (4) @(negedge clk);
        rx_def = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_valid", 32'(vcnt_def - base), 32'd0);
        base = vcnt_def;
        send_frame(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);
        repeat (4) @(negedge clk);
        check("post_glitch_vcycles", 32'(vcnt_def - base), 32'd1);
        check("post_glitch_data",    32'(cap_data_def), 32'h3C);

        // Overrun: two frames with no consumer, then one accept cycle.
        rdy_def = 1'b0;
        send_frame(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
        check("ovr1_valid", 32'(valid_def), 32'h1);
        check("ovr1_data",  32'(data_def), 32'h11);
        check("ovr1_ov",    32'(ov_def), 32'h0);
        send_frame(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
        check("ovr2_valid", 32'(valid_def), 32'h1);
        check("ovr2_data",  32'(data_def), 32'h22);
        check("ovr2_ov",    32'(ov_def), 32'h1);
        rdy_def = 1'b1;
        @(negedge clk);
        rdy_def = 1'b0;
        check("accept_valid", 32'(valid_def), 32'h0);
        check("accept_ov",    32'(ov_def), 32'h0);

        // Two stop bits, second one low: delivered with frame_err.
        rdy_s2 = 1'b0;
        send_frame(2, {5'b0, 1'b0, 1'b1, 8'h7E, 1'b0}, 11);
        check("stop2_valid", 32'(valid_s2), 32'h1);
        check("stop2_data",  32'(data_s2), 32'h7E);
        check("stop2_fe",    32'(fe_s2), 32'h1);
        check("stop2_pe",    32'(pe_s2), 32'h0);

        // With clock_enable low the accept is ignored and valid holds.
        ce = 1'b0;
        rdy_s2 = 1'b1;
        repeat (3) @(negedge clk);
        check("ce_hold_valid", 32'(valid_s2), 32'h1);
        ce = 1'b1;
        @(negedge clk);
        check("ce_accept_valid", 32'(valid_s2), 32'h0);

        // Reset during data bit 3 of 0x33 abandons that frame.
        rdy_def = 1'b1;
        rx_def = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_def = 1'b1;
        repeat (CPB) @(negedge clk);
        rx_def = 1'b1;
        repeat (CPB) @(negedge clk);
        rx_def = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_def = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_data",  32'(data_def), 32'h0);
        check("midrst_valid", 32'(valid_def), 32'h0);
        check("midrst_pe",    32'(pe_def), 32'h0);
        check("midrst_fe",    32'(fe_def), 32'h0);
        check("midrst_ov",    32'(ov_def), 32'h0);
        rx_def = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        base = vcnt_def;
        send_frame(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
        repeat (20) @(negedge clk);
        check("after_rst_vcycles", 32'(vcnt_def - base), 32'd1);
        check("after_rst_data",    32'(cap_data_def), 32'h5A);
        check("after_rst_pe",      32'(cap_pe_def), 32'h0);
        check("after_rst_fe",      32'(cap_fe_def), 32'h0);
        check("after_rst_ov",      32'(ov_def), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
